// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   XLEN_DEFAULT      : default PC/address width
//   NOP_INSTR_DEFAULT : bubble encoding (addi x0,x0,0)
//   fetch_state_e     : request FSM state (FETCH / WAIT / HOLD)
//   ifid_t            : one IF/ID pipeline-register entry
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT      = 64;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // free to issue a request
        WAIT  = 2'd1,   // one request outstanding, waiting for its response
        HOLD  = 2'd2    // response parked in the skid buffer, decode stalled
    } fetch_state_e;

    // The PC fields are sized by XLEN_DEFAULT; the fetch_stage XLEN parameter
    // is expected to stay at this value.
    typedef struct packed {
        logic [31:0]             instr;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pc_plus4;
        logic                    valid;
    } ifid_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for an instruction response that arrived while
// decode could not accept it.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en_i    : capture data_i, buffer becomes full
//   rd_en_i    : entry consumed, buffer becomes empty
//   clr_i      : discard the entry (redirect); wins over write and read
//   data_i     : entry to capture
//   data_o     : stored entry (meaningful only while full_o is set)
//   full_o     : buffer holds an entry
// ---------------------------------------------------------------------------
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en_i,
    input  logic  rd_en_i,
    input  logic  clr_i,
    input  ifid_t data_i,
    output ifid_t data_o,
    output logic  full_o
);

    logic  full_q;
    logic  full_d;
    ifid_t data_q;

    always_comb begin
        full_d = full_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (wr_en_i) begin
            full_d = 1'b1;
        end else if (rd_en_i) begin
            full_d = 1'b0;
        end
    end

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // NOTE: the payload is deliberately not reset; it is only observed while
    // full_q is set, and full_q is reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage RV64 pipeline. Owns the PC, runs a
// single-outstanding-request instruction-memory handshake and drives the
// IF/ID pipeline register. Redirects from decode kill in-flight responses;
// a one-entry skid buffer absorbs responses that arrive while decode stalls.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   PCSF          : redirect request from decode (taken branch/jump)
//   PCTargetD     : redirect target
//   StallF        : issue no new request
//   StallD        : hold IF/ID
//   FlushD        : load a bubble into IF/ID
//   ImemReq       : request valid
//   ImemAddr      : request address (current PC)
//   ImemGnt       : request accepted this cycle (ignored unless requesting)
//   ImemRvalid    : response valid
//   ImemRdata     : response instruction
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID register contents
//   FetchCountO   : real instructions loaded into IF/ID (saturating)
//   BubbleCountO  : bubbles loaded into IF/ID (saturating)
//
// Build option: define FETCH_STATS_EN to add FetchCountO/BubbleCountO and
// their counters; without it those ports do not exist.
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSF,
    input  logic [XLEN-1:0] PCTargetD,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRvalid,
    input  logic [31:0]     ImemRdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     FetchCountO,
    output logic [31:0]     BubbleCountO
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pc_req_q, pc_req_d;   // address of the outstanding request
    logic            kill_q, kill_d;       // outstanding response must be dropped
    ifid_t           ifid_q, ifid_d;
    logic            ifid_load;

    logic            req_fire;
    ifid_t           bubble;
    ifid_t           resp;

    logic            skid_wr, skid_rd, skid_clr, skid_full;
    ifid_t           skid_data;

    // A bubble carries the same fields as the post-reset IF/ID contents.
    assign bubble = '{instr: NOP_INSTR, pc: '0, pc_plus4: XLEN'(4), valid: 1'b0};
    assign resp   = '{instr: ImemRdata, pc: pc_req_q, pc_plus4: pc_req_q + XLEN'(4), valid: 1'b1};

    assign req_fire = ImemReq && ImemGnt;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (skid_wr),
        .rd_en_i (skid_rd),
        .clr_i   (skid_clr),
        .data_i  (resp),
        .data_o  (skid_data),
        .full_o  (skid_full)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pcf_q    <= RESET_PC;
            pc_req_q <= '0;
            kill_q   <= 1'b0;
            ifid_q   <= bubble;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            pc_req_q <= pc_req_d;
            kill_q   <= kill_d;
            if (ifid_load) begin
                ifid_q <= ifid_d;
            end
        end
    end

    // ---------------- next-state / datapath ----------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned and infers a latch.
        state_d   = state_q;
        pcf_d     = pcf_q;
        pc_req_d  = pc_req_q;
        kill_d    = kill_q;
        ifid_load = 1'b0;
        ifid_d    = bubble;
        skid_wr   = 1'b0;
        skid_rd   = 1'b0;
        skid_clr  = 1'b0;

        // Baseline IF/ID policy when nothing is delivered: a redirect or flush
        // forces a bubble, an unstalled decode takes a bubble, otherwise hold.
        if (PCSF || FlushD || !StallD) begin
            ifid_load = 1'b1;
        end

        if (PCSF) begin
            pcf_d    = PCTargetD;
            skid_clr = 1'b1;
        end

        case (state_q)
            FETCH: begin
                if (req_fire) begin
                    state_d = WAIT;
                    if (PCSF) begin
                        // Request left with the stale address: drop its response.
                        kill_d = 1'b1;
                    end else begin
                        pc_req_d = pcf_q;
                        pcf_d    = pcf_q + XLEN'(4);
                    end
                end
            end

            WAIT: begin
                if (ImemRvalid) begin
                    if (PCSF || kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else if (!StallD && !FlushD) begin
                        ifid_load = 1'b1;
                        ifid_d    = resp;
                        state_d   = FETCH;
                    end else begin
                        skid_wr = 1'b1;
                        state_d = HOLD;
                    end
                end else if (PCSF) begin
                    kill_d = 1'b1;
                end
            end

            HOLD: begin
                if (PCSF) begin
                    state_d = FETCH;
                end else if (!FlushD && !StallD && skid_full) begin
                    // A flush here loads a bubble and keeps the parked entry.
                    ifid_load = 1'b1;
                    ifid_d    = skid_data;
                    skid_rd   = 1'b1;
                    state_d   = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        ImemReq = (state_q == FETCH) && !StallF && !rst;
    end

    assign ImemAddr = pcf_q;
    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pc_plus4;
    assign ValidD   = ifid_q.valid;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ifid_load) begin
            if (ifid_d.valid) begin
                if (fetch_cnt_q != '1) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end else if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign FetchCountO  = fetch_cnt_q;
    assign BubbleCountO = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Table-driven bench for fetch_stage. Each table row gives one cycle of
// inputs plus the expected ImemReq/ImemAddr; rows that carry a response the
// stage must deliver push {instr, pc} to a scoreboard, which a monitor pops
// whenever IF/ID is loaded with a valid instruction.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst;
        logic        pcsf;
        logic [63:0] target;
        logic        stallf;
        logic        stalld;
        logic        flushd;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        push;
        logic [63:0] push_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        PCSF;
    logic [63:0] PCTargetD;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic [31:0] InstrD;
    logic [63:0] PCD;
    logic [63:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_STATS_EN
    logic [31:0] FetchCountO;
    logic [31:0] BubbleCountO;
    int unsigned exp_fetch;
    int unsigned exp_bubble;
`endif

    int   n_cmp;
    int   n_err;
    vec_t vecs[$];
    exp_t sb[$];
    logic mon_en;

    logic [31:0] prev_instr;
    logic [63:0] prev_pc;
    logic [63:0] prev_pc4;
    logic        prev_valid;
    logic        ld;
    logic        ld_rst;
    exp_t        e;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .PCSF       (PCSF),
        .PCTargetD  (PCTargetD),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRvalid (ImemRvalid),
        .ImemRdata  (ImemRdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
`ifdef FETCH_STATS_EN
        ,
        .FetchCountO  (FetchCountO),
        .BubbleCountO (BubbleCountO)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic pcsf, input logic [63:0] tgt,
                       input logic stf, input logic std, input logic fld,
                       input logic gnt, input logic rv, input logic [31:0] rdata,
                       input logic exp_req, input logic [63:0] exp_addr,
                       input logic push, input logic [63:0] push_pc);
        vec_t v;
        v.rst = r; v.pcsf = pcsf; v.target = tgt; v.stallf = stf; v.stalld = std;
        v.flushd = fld; v.gnt = gnt; v.rvalid = rv; v.rdata = rdata;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.push = push; v.push_pc = push_pc;
        vecs.push_back(v);
    endtask

    task automatic add_reset();
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Applies the table one row per cycle, then checks the scoreboard drained.
    task automatic run_table(input string name);
        exp_t x;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            PCSF       = vecs[i].pcsf;
            PCTargetD  = vecs[i].target;
            StallF     = vecs[i].stallf;
            StallD     = vecs[i].stalld;
            FlushD     = vecs[i].flushd;
            ImemGnt    = vecs[i].gnt;
            ImemRvalid = vecs[i].rvalid;
            ImemRdata  = vecs[i].rdata;
            #1;
            check({name, ".imem_req"}, ImemReq, vecs[i].exp_req);
            if (!vecs[i].rst) begin
                check({name, ".imem_addr"}, ImemAddr, vecs[i].exp_addr);
            end
            if (vecs[i].push) begin
                x.instr = vecs[i].rdata;
                x.pc    = vecs[i].push_pc;
                sb.push_back(x);
            end
        end
        @(posedge clk);
        #2;
        check({name, ".sb_drained"}, 64'(sb.size()), 0);
        sb.delete();
        vecs.delete();
    endtask

    // IF/ID monitor: every edge either loads (bubble or instruction) or holds.
    always @(posedge clk) begin
        if (mon_en) begin
            ld_rst = rst;
            ld     = rst || PCSF || FlushD || !StallD;
            #1;
            if (ld && ValidD === 1'b1 && !ld_rst) begin
                check("ifid.sb_has_entry", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("ifid.instr", InstrD, e.instr);
                    check("ifid.pc", PCD, e.pc);
                    check("ifid.pc_plus4", PCPlus4D, e.pc + 64'd4);
                end
            end else if (ld) begin
                check("bubble.valid", ValidD, 0);
                check("bubble.instr", InstrD, NOP);
                check("bubble.pc", PCD, 0);
                check("bubble.pc_plus4", PCPlus4D, 4);
            end else begin
                check("hold.instr", InstrD, prev_instr);
                check("hold.pc", PCD, prev_pc);
                check("hold.pc_plus4", PCPlus4D, prev_pc4);
                check("hold.valid", ValidD, prev_valid);
            end
`ifdef FETCH_STATS_EN
            if (ld_rst) begin
                exp_fetch  = 0;
                exp_bubble = 0;
            end else if (ld) begin
                if (ValidD === 1'b1) exp_fetch++;
                else exp_bubble++;
            end
            check("stats.fetch", FetchCountO, 64'(exp_fetch));
            check("stats.bubble", BubbleCountO, 64'(exp_bubble));
`endif
            prev_instr = InstrD;
            prev_pc    = PCD;
            prev_pc4   = PCPlus4D;
            prev_valid = ValidD;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; mon_en = 1'b0;
        rst = 1'b1; PCSF = 1'b0; PCTargetD = '0; StallF = 1'b0; StallD = 1'b0;
        FlushD = 1'b0; ImemGnt = 1'b0; ImemRvalid = 1'b0; ImemRdata = '0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Hand-written reset sequence: request suppressed during reset,
        // reset values visible afterwards.
        @(negedge clk);
        rst = 1'b1; ImemGnt = 1'b1;
        #1;
        check("reset.imem_req", ImemReq, 0);
        @(posedge clk);
        #2;
        check("reset.imem_addr", ImemAddr, 0);
        check("reset.instr", InstrD, NOP);
        check("reset.pcd", PCD, 0);
        check("reset.pc_plus4", PCPlus4D, 4);
        check("reset.valid", ValidD, 0);
        @(negedge clk);
        rst = 1'b0; ImemGnt = 1'b0;
        #1;
        check("post_reset.imem_req", ImemReq, 1);

        // Basic stream: addresses 0,4,8 with one-cycle responses.
        add_reset();
        add(0, 0, 0, 0, 0, 0, 1, 0, 0,             1, 64'h0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 32'h0000_0013, 0, 64'h4, 1, 64'h0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0,             1, 64'h4, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 1, 32'h0010_0093, 0, 64'h8, 1, 64'h4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 64'h8, 0, 0);
        run_table("basic");

        // Redirect while waiting; stale response arrives two cycles later.
        add_reset();
        add(0, 0, 0,      0, 0, 0, 1, 0, 0,             1, 64'h0,   0, 0);
        add(0, 1, 64'h100, 0, 0, 0, 0, 0, 0,            0, 64'h4,   0, 0);
        add(0, 0, 0,      0, 0, 0, 0, 0, 0,             0, 64'h100, 0, 0);
        add(0, 0, 0,      0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 64'h100, 0, 0);
        add(0, 0, 0,      0, 0, 0, 1, 0, 0,             1, 64'h100, 0, 0);
        add(0, 0, 0,      0, 0, 0, 0, 1, 32'h0020_0113, 0, 64'h104, 1, 64'h100);
        add(0, 0, 0,      0, 0, 0, 0, 0, 0,             1, 64'h104, 0, 0);
        run_table("redirect_wait");

        // Redirect to 0x8 from FETCH, then redirect coinciding with the grant.
        add_reset();
        add(0, 1, 64'h8,   0, 0, 0, 0, 0, 0,             1, 64'h0,   0, 0);
        add(0, 1, 64'h200, 0, 0, 0, 1, 0, 0,             1, 64'h8,   0, 0);
        add(0, 0, 0,       0, 0, 0, 1, 0, 0,             0, 64'h200, 0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 1, 32'h0BAD_0BAD, 0, 64'h200, 0, 0);
        add(0, 0, 0,       0, 0, 0, 1, 0, 0,             1, 64'h200, 0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 1, 32'h0030_0193, 0, 64'h204, 1, 64'h200);
        add(0, 0, 0,       0, 0, 0, 0, 0, 0,             1, 64'h204, 0, 0);
        run_table("redirect_grant");

        // StallD for three cycles across the response: parked in the skid.
        add_reset();
        add(0, 0, 0, 0, 0, 0, 1, 0, 0,             1, 64'h0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0093, 0, 64'h4, 1, 64'h0);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0,             1, 64'h4, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 32'hABCD_E0B7, 0, 64'h8, 1, 64'h4);
        add(0, 0, 0, 0, 1, 0, 1, 0, 0,             0, 64'h8, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 64'h8, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 64'h8, 0, 0);
        run_table("stall_skid");

        // FlushD together with rvalid: bubble now, instruction next cycle.
        add_reset();
        add(0, 0, 0, 0, 0, 0, 1, 0, 0,             1, 64'h0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 1, 32'h0050_0293, 0, 64'h4, 1, 64'h0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             0, 64'h4, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 64'h4, 0, 0);
        run_table("flush_rvalid");

        // StallF in FETCH: no request, grant ignored, PC held.
        add_reset();
        add(0, 0, 0, 1, 0, 0, 1, 0, 0,             0, 64'h0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0,             0, 64'h0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0,             1, 64'h0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0060_0313, 0, 64'h4, 1, 64'h0);
        run_table("stallf");

        // Reset in WAIT; the late response must not reach IF/ID.
        add_reset();
        add(0, 0, 0, 0, 0, 0, 1, 0, 0,             1, 64'h0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0,             0, 64'h4, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111, 1, 64'h0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 64'h0, 0, 0);
        run_table("rst_wait");

        // PC wrap at the top of the address space.
        add_reset();
        add(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0, 1, 64'h0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0,             1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0070_0393, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0,             1, 64'h0, 0, 0);
        run_table("pc_wrap");

        // Redirect while HOLD and StallD: bubble anyway, skid entry discarded.
        add_reset();
        add(0, 0, 0,       0, 0, 0, 1, 0, 0,             1, 64'h0,   0, 0);
        add(0, 0, 0,       0, 1, 0, 0, 1, 32'h0080_0413, 0, 64'h4,   0, 0);
        add(0, 0, 0,       0, 1, 0, 0, 0, 0,             0, 64'h4,   0, 0);
        add(0, 1, 64'h300, 0, 1, 0, 0, 0, 0,             0, 64'h4,   0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 0, 0,             1, 64'h300, 0, 0);
        add(0, 0, 0,       0, 0, 0, 0, 0, 0,             1, 64'h300, 0, 0);
        run_table("redirect_hold");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
